// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Registered result with start/busy/done handshake and optional sign-magnitude mode.
module binary_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                neg,
    output logic                overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam bit IS_SIGNED = (SIGNED != 0);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [BCD_W-1:0]   corr;
    logic               ovf_scr_q, ovf_scr_d;
    logic               pend_neg_q, pend_neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               in_neg;

    assign in_neg = IS_SIGNED && bin_in[BIN_W-1];

    // Add-3 correction of every scratch digit that would exceed 9 after doubling.
    always_comb begin
        corr = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                corr[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        scr_d      = scr_q;
        ovf_scr_d  = ovf_scr_q;
        pend_neg_d = pend_neg_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // The unsigned reading of -bin_in is exact even for the most negative input.
                    mag_d      = in_neg ? (~bin_in + 1'b1) : bin_in;
                    pend_neg_d = in_neg;
                    scr_d      = '0;
                    ovf_scr_d  = 1'b0;
                    cnt_d      = CNT_W'(BIN_W);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scr_d     = {corr[BCD_W-2:0], mag_q[BIN_W-1]};
                mag_d     = {mag_q[BIN_W-2:0], 1'b0};
                ovf_scr_d = ovf_scr_q | corr[BCD_W-1];
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_d;
                    neg_d   = pend_neg_q;
                    ovf_d   = ovf_scr_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            scr_q      <= '0;
            ovf_scr_q  <= 1'b0;
            pend_neg_q <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            scr_q      <= scr_d;
            ovf_scr_q  <= ovf_scr_d;
            pend_neg_q <= pend_neg_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign neg      = neg_q;
    assign overflow = ovf_q;

endmodule

// File: doc/binary_bcd_seq.md
Name: binary_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-add-3 (double-dabble).
- Processes one input bit per clock with a start/busy/done handshake.
- Generalises the combinational 8-bit/3-digit converter to any input width and digit count, with an optional signed (sign-magnitude) mode and an overflow flag.
- Sits between the arithmetic datapath and the 7-segment display driver, and registers its result so the display sees stable digits.

Parameters:
- BIN_W, 8: input binary width in bits (>=2).
- DIGITS, 3: number of BCD output digits (>=1).
- SIGNED, 0: 0 = bin_in is unsigned; 1 = bin_in is two's complement, and the output is sign + magnitude.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  in  BIN_W  value to convert; sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse; bcd_out, neg and overflow are valid and updated.
- bcd_out  out  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], and digit 0 is ones.
- neg  out  1  sign of the last result (always 0 when SIGNED=0).
- overflow  out  1  the last result did not fit in DIGITS digits.

Behaviour:
- Reset (async, any time): state=IDLE; busy=0, done=0, bcd_out=0, neg=0, overflow=0; shift register and counter cleared. Reset mid-conversion aborts it: no done pulse, and the previous bcd_out is discarded (it reads 0).
- States:
  - IDLE:
    - busy=0.
    - If start is high at an edge: load.
      - mag = bin_in, or -bin_in if SIGNED=1 and bin_in[BIN_W-1]=1. The BIN_W-bit unsigned magnitude is correct for -2^(BIN_W-1).
      - Capture the sign as pending_neg.
      - Clear the BCD scratch and the overflow scratch.
      - cnt = BIN_W.
      - Go to SHIFT. busy=1 from this edge.
  - SHIFT:
    - On each edge, every scratch digit >=5 gets +3 (4-bit, all digits in parallel).
    - Then the {scratch, mag} concatenation shifts left 1.
    - A 1 shifted out of the top digit sets the overflow scratch (sticky).
    - cnt decrements by 1.
    - On the edge where cnt==1 (the BIN_W-th shift):
      - Write the final corrected/shifted scratch to bcd_out, pending_neg to neg, and the overflow scratch (including the bit shifted out on this edge) to overflow.
      - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: the start-accepting edge is edge 0; done and the new outputs appear after edge BIN_W.
- Throughput: one conversion per BIN_W+1 cycles. A start held high while done=1 is accepted at that edge (back-to-back).
- start while busy: ignored, and not queued. bin_in changes during SHIFT have no effect.
- Outputs hold their last values between done pulses. bcd_out never shows intermediate scratch values.
- Overflow: bcd_out equals the true magnitude mod 10^DIGITS. A sufficient DIGITS is ceil(BIN_W*log10(2)) + (SIGNED ? 0 : 0), e.g. 8->3 and 16->5. overflow must stay 0 whenever DIGITS is sufficient.
- Zero input: bcd_out=0, neg=0 (-0 cannot occur), overflow=0.
- cnt width: clog2(BIN_W+1). No combinational path from start or bin_in to any output.

Test Plan:
- Default params, reset then start with bin_in=8'd255 for one cycle:
  - busy=1 for 8 cycles.
  - done pulses once after edge 8.
  - bcd_out=12'h255, neg=0, overflow=0.
- bin_in=0, then 8'd9, then 8'd100, back-to-back with start held high:
  - Results 12'h000, 12'h009, 12'h100.
  - done pulses spaced 9 cycles apart; no conversion is lost.
- SIGNED=1, BIN_W=8:
  - bin_in=8'h80 -> bcd_out=12'h128, neg=1.
  - bin_in=8'hFF -> bcd_out=12'h001, neg=1.
  - bin_in=8'd127 -> bcd_out=12'h127, neg=0.
- BIN_W=16, DIGITS=5, bin_in=16'd65535 -> bcd_out=20'h65535 after 16 cycles, overflow=0.
- DIGITS=2, BIN_W=8, bin_in=8'd200 -> bcd_out=8'h00, overflow=1. A following conversion of 8'd42 -> bcd_out=8'h42, overflow=0.
- Start a conversion of 8'd255, pulse start again at cycle 3 and assert reset at cycle 5:
  - The second start is ignored.
  - After reset, all outputs are 0 and no done pulse occurs.
  - A fresh start of 8'd37 yields 12'h037.
